// File: rtl/memory_scan.sv
// Scans three read banks (2048/1024/512 words) against PATTERN through a one-stage read pipeline.
// A scan takes 3585 busy cycles followed by a one-cycle done; start is ignored unless idle.
module memory_scan #(
    parameter logic [15:0] PATTERN = 16'hFFFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic [12:0] rd_addr,
    output logic [2:0]  rd_sel,
    input  logic [15:0] q1,
    input  logic [15:0] q2,
    input  logic [15:0] q3,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [11:0] err_count,
    output logic [12:0] first_err_addr,
    output logic [7:0]  out
);

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN, REPORT} state_t;

    localparam logic [12:0] LAST_ADDR = 13'd3583;
    localparam logic [12:0] NO_ERR    = 13'h1FFF;

    state_t      state, state_nxt;
    logic [12:0] d_addr;
    logic [2:0]  d_sel;
    logic        d_vld;
    logic [15:0] sel_q;
    logic        mismatch;
    logic [11:0] err_nxt;
    logic [7:0]  result_byte;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = SCAN;
            SCAN:    if (rd_addr == LAST_ADDR) state_nxt = DRAIN;
            DRAIN:   state_nxt = REPORT;
            REPORT:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Bank boundaries at 2048 and 3072 fall on address bits 11 and 10.
    always_comb begin
        rd_sel = 3'b000;
        if (state == SCAN) begin
            if (!rd_addr[11])      rd_sel = 3'b001;
            else if (!rd_addr[10]) rd_sel = 3'b010;
            else                   rd_sel = 3'b100;
        end
    end

    always_comb begin
        sel_q = q1;
        if (d_sel[1])      sel_q = q2;
        else if (d_sel[2]) sel_q = q3;
    end

    assign mismatch = d_vld && (sel_q != PATTERN);
    assign err_nxt  = (mismatch && err_count != 12'hFFF) ? err_count + 12'd1 : err_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_addr        <= 13'd0;
            d_addr         <= 13'd0;
            d_sel          <= 3'b000;
            d_vld          <= 1'b0;
            err_count      <= 12'd0;
            first_err_addr <= NO_ERR;
            pass           <= 1'b0;
            result_byte    <= 8'h00;
        end else begin
            d_vld  <= (state == SCAN);
            d_sel  <= rd_sel;
            d_addr <= rd_addr;
            if (state == IDLE && start) begin
                rd_addr        <= 13'd0;
                err_count      <= 12'd0;
                first_err_addr <= NO_ERR;
                pass           <= 1'b0;
            end else begin
                if (state == SCAN && rd_addr != LAST_ADDR)
                    rd_addr <= rd_addr + 13'd1;
                err_count <= err_nxt;
                // NO_ERR is never a scanned address, so it doubles as the "none yet" flag.
                if (mismatch && first_err_addr == NO_ERR)
                    first_err_addr <= d_addr;
                if (state == DRAIN) begin
                    pass <= (err_nxt == 12'd0);
                    if (err_nxt == 12'd0)
                        result_byte <= 8'hA5;
                    else
                        result_byte <= {1'b1, (err_nxt > 12'd127) ? 7'h7F : err_nxt[6:0]};
                end
            end
        end
    end

    assign busy = (state == SCAN) || (state == DRAIN);
    assign done = (state == REPORT);
    assign out  = busy ? rd_addr[12:5] : result_byte;

endmodule

// File: tb/tb_memory_scan.sv
// Directed bench for memory_scan: table of memory images with expected scan results,
// plus hand sequences for mid-scan reset and start held high.
module tb_memory_scan;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [12:0] rd_addr;
    logic [2:0]  rd_sel;
    logic [15:0] q1, q2, q3;
    logic        busy, done, pass;
    logic [11:0] err_count;
    logic [12:0] first_err_addr;
    logic [7:0]  out;

    int checks = 0;
    int errors = 0;

    logic [15:0] mem [0:3583];

    memory_scan #(.PATTERN(16'hFFFF)) dut (
        .clk(clk), .reset(reset), .start(start),
        .rd_addr(rd_addr), .rd_sel(rd_sel),
        .q1(q1), .q2(q2), .q3(q3),
        .busy(busy), .done(done), .pass(pass),
        .err_count(err_count), .first_err_addr(first_err_addr), .out(out)
    );

    always #5 clk = ~clk;

    // Registered bank reads: data appears one cycle after the address.
    always @(posedge clk) begin
        if (rd_sel[0]) q1 <= mem[rd_addr];
        if (rd_sel[1]) q2 <= mem[rd_addr];
        if (rd_sel[2]) q3 <= mem[rd_addr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [2:0] exp_sel(input int a);
        if (a < 2048)      return 3'b001;
        else if (a < 3072) return 3'b010;
        else               return 3'b100;
    endfunction

    task automatic fill(input bit zero, input logic [12:0] a1, input logic [15:0] v1,
                        input logic [12:0] a2, input logic [15:0] v2);
        for (int i = 0; i < 3584; i++) mem[i] = zero ? 16'h0000 : 16'hFFFF;
        mem[a1] = v1;
        mem[a2] = v2;
    endtask

    task automatic run_scan(input string tag, input logic e_pass, input logic [11:0] e_err,
                            input logic [12:0] e_first, input logic [7:0] e_out,
                            input bit poke10, input bit poke_rep);
        int nbusy, ndone, seq_bad, idle_bad;
        bit finished;
        logic r_pass, r_sel0;
        logic [11:0] r_err;
        logic [12:0] r_first;
        logic [7:0]  r_out;
        logic [12:0] k13;
        nbusy = 0; ndone = 0; seq_bad = 0; idle_bad = 0; finished = 0;
        r_pass = 1'bx; r_err = 'x; r_first = 'x; r_out = 'x; r_sel0 = 1'bx;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        for (int t = 0; t < 4000 && !finished; t++) begin
            if (t > 0) @(negedge clk);
            start = (poke10 && t == 10) || (poke_rep && done);
            if (busy) begin
                if (t < 3584) begin
                    k13 = 13'(t);
                    if (rd_addr !== k13 || rd_sel !== exp_sel(t) || out !== k13[12:5]) seq_bad++;
                end else if (rd_sel !== 3'b000) seq_bad++;
                nbusy++;
            end
            if (done) begin
                ndone++;
                r_pass = pass; r_err = err_count; r_first = first_err_addr;
                r_out = out; r_sel0 = (rd_sel == 3'b000);
            end
            if (!busy && !done && ndone > 0) finished = 1;
        end
        start = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (busy || done || rd_sel !== 3'b000) idle_bad++;
        end
        chk({tag, " busy_cycles"}, nbusy, 3585);
        chk({tag, " done_pulses"}, ndone, 1);
        chk({tag, " addr_sel_sequence"}, seq_bad, 0);
        chk({tag, " pass"}, r_pass, e_pass);
        chk({tag, " err_count"}, r_err, e_err);
        chk({tag, " first_err_addr"}, r_first, e_first);
        chk({tag, " out_report"}, r_out, e_out);
        chk({tag, " rd_sel_report"}, r_sel0, 1'b1);
        chk({tag, " idle_quiet"}, idle_bad, 0);
        chk({tag, " pass_held"}, pass, e_pass);
        chk({tag, " err_held"}, err_count, e_err);
        chk({tag, " out_held"}, out, e_out);
    endtask

    typedef struct {
        string       name;
        bit          zero_fill;
        logic [12:0] a1;
        logic [15:0] v1;
        logic [12:0] a2;
        logic [15:0] v2;
        logic        e_pass;
        logic [11:0] e_err;
        logic [12:0] e_first;
        logic [7:0]  e_out;
        bit          poke10;
        bit          poke_rep;
    } vec_t;

    vec_t vecs [7];

    initial begin
        int wait_n, quiet_bad, gap;
        bit hit;
        vecs[0] = '{"all_ok",     1'b0, 13'd0,    16'hFFFF, 13'd0,    16'hFFFF, 1'b1, 12'd0,     13'h1FFF, 8'hA5, 1'b1, 1'b1};
        vecs[1] = '{"two_err",    1'b0, 13'd2048, 16'hFFFE, 13'd3583, 16'h0000, 1'b0, 12'd2,     13'd2048, 8'h82, 1'b0, 1'b1};
        vecs[2] = '{"all_zero",   1'b1, 13'd0,    16'h0000, 13'd0,    16'h0000, 1'b0, 12'hE00,   13'd0,    8'hFF, 1'b0, 1'b0};
        vecs[3] = '{"all_zero2",  1'b1, 13'd0,    16'h0000, 13'd0,    16'h0000, 1'b0, 12'hE00,   13'd0,    8'hFF, 1'b0, 1'b0};
        vecs[4] = '{"bank0_edges",1'b0, 13'd0,    16'h7FFF, 13'd2047, 16'hFFF7, 1'b0, 12'd2,     13'd0,    8'h82, 1'b1, 1'b0};
        vecs[5] = '{"bank12_edge",1'b0, 13'd3071, 16'h0000, 13'd3072, 16'h1234, 1'b0, 12'd2,     13'd3071, 8'h82, 1'b0, 1'b0};
        vecs[6] = '{"last_word",  1'b0, 13'd3583, 16'hFFEF, 13'd3583, 16'hFFEF, 1'b0, 12'd1,     13'd3583, 8'h81, 1'b0, 1'b0};

        start = 1'b0;
        reset = 1'b1;
        fill(1'b0, 13'd0, 16'hFFFF, 13'd0, 16'hFFFF);
        #23;
        chk("rst busy", busy, 1'b0);
        chk("rst done", done, 1'b0);
        chk("rst pass", pass, 1'b0);
        chk("rst err_count", err_count, 12'd0);
        chk("rst first_err_addr", first_err_addr, 13'h1FFF);
        chk("rst out", out, 8'h00);
        chk("rst rd_sel", rd_sel, 3'b000);
        chk("rst rd_addr", rd_addr, 13'd0);
        @(negedge clk) reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle out before scan", out, 8'h00);

        foreach (vecs[i]) begin
            fill(vecs[i].zero_fill, vecs[i].a1, vecs[i].v1, vecs[i].a2, vecs[i].v2);
            run_scan(vecs[i].name, vecs[i].e_pass, vecs[i].e_err, vecs[i].e_first,
                     vecs[i].e_out, vecs[i].poke10, vecs[i].poke_rep);
        end

        // Reset asserted mid-scan at address 1000, after a mismatch at 500 was recorded.
        fill(1'b0, 13'd500, 16'h0000, 13'd500, 16'h0000);
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        hit = 0;
        for (int t = 0; t < 2000 && !hit; t++) begin
            if (rd_addr == 13'd1000 && busy) hit = 1;
            else @(negedge clk);
        end
        chk("midrst reached addr 1000", hit, 1'b1);
        chk("midrst first_err before", first_err_addr, 13'd500);
        #1 reset = 1'b1;
        #1;
        chk("midrst busy", busy, 1'b0);
        chk("midrst done", done, 1'b0);
        chk("midrst rd_sel", rd_sel, 3'b000);
        chk("midrst rd_addr", rd_addr, 13'd0);
        chk("midrst pass", pass, 1'b0);
        chk("midrst err_count", err_count, 12'd0);
        chk("midrst first_err_addr", first_err_addr, 13'h1FFF);
        chk("midrst out", out, 8'h00);
        @(negedge clk) reset = 1'b0;
        quiet_bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (busy || done || err_count != 12'd0) quiet_bad++;
        end
        chk("midrst quiet after release", quiet_bad, 0);
        fill(1'b0, 13'd0, 16'hFFFF, 13'd0, 16'hFFFF);
        run_scan("after_reset", 1'b1, 12'd0, 13'h1FFF, 8'hA5, 1'b0, 1'b0);

        // start held high: back-to-back scans separated by exactly one idle cycle.
        fill(1'b0, 13'd2500, 16'h00FF, 13'd2500, 16'h00FF);
        @(negedge clk) start = 1'b1;
        wait_n = 0;
        while (!done && wait_n < 4000) begin @(negedge clk); wait_n++; end
        chk("held first done seen", done, 1'b1);
        chk("held first err_count", err_count, 12'd1);
        gap = 0;
        for (int t = 0; t < 10; t++) begin
            @(negedge clk);
            if (busy) break;
            gap++;
        end
        chk("held idle gap", gap, 1);
        chk("held restart cleared err", err_count, 12'd0);
        wait_n = 0;
        while (!done && wait_n < 4000) begin @(negedge clk); wait_n++; end
        chk("held second done seen", done, 1'b1);
        chk("held second err_count", err_count, 12'd1);
        chk("held second first_err", first_err_addr, 13'd2500);
        start = 1'b0;
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
